// File: rtl/tqvp_jnms_pdm_seq_if.sv
// PDM capture sequencer bus bundle.
// Groups configuration, microphone data, interrupt handshakes and the
// captured bit stream between the register block (master) and the
// sequencer (slave). bit_chan exists only when TQVP_JNMS_PDM_STEREO_EN
// is defined.
interface tqvp_jnms_pdm_seq_if #(
    parameter int DIV_W   = 8,
    parameter int WARM_W  = 16,
    parameter int DECIM_W = 8
);
    logic               enable;
    logic [DIV_W-1:0]   clk_half_period;
    logic [WARM_W-1:0]  warmup_periods;
    logic [DECIM_W-1:0] decim_ratio;
    logic               edge_sel;
    logic               pdm_data_in;
    logic               sample_ack;
    logic               overrun_clr;
    logic               pdm_clk_out;
    logic               bit_valid;
    logic               bit_data;
    logic               pcm_tick;
    logic [1:0]         state;
    logic               irq;
    logic               overrun;
`ifdef TQVP_JNMS_PDM_STEREO_EN
    logic               bit_chan;
`endif

    modport master (
        output enable, clk_half_period, warmup_periods, decim_ratio, edge_sel,
        output pdm_data_in, sample_ack, overrun_clr,
        input  pdm_clk_out, bit_valid, bit_data, pcm_tick, state, irq, overrun
`ifdef TQVP_JNMS_PDM_STEREO_EN
        , input bit_chan
`endif
    );

    modport slave (
        input  enable, clk_half_period, warmup_periods, decim_ratio, edge_sel,
        input  pdm_data_in, sample_ack, overrun_clr,
        output pdm_clk_out, bit_valid, bit_data, pcm_tick, state, irq, overrun
`ifdef TQVP_JNMS_PDM_STEREO_EN
        , output bit_chan
`endif
    );
endinterface

// File: rtl/tqvp_jnms_pdm_seq.sv
// PDM microphone capture sequencer.
// Generates the PDM clock from clk, discards a warm-up period after enable,
// then samples pdm_data_in on the latched edge, strobes each bit out and
// issues pcm_tick every decim_ratio bits. Owns the sample-ready irq and the
// sticky overrun flag.
// Ports: clk, rst (async active-high), bus (tqvp_jnms_pdm_seq_if.slave):
//   config inputs enable/clk_half_period/warmup_periods/decim_ratio/edge_sel,
//   pdm_data_in, sample_ack, overrun_clr; outputs pdm_clk_out, bit_valid,
//   bit_data, pcm_tick, state, irq, overrun.
// Optional: TQVP_JNMS_PDM_STEREO_EN samples both PDM clock edges and adds
//   bus.bit_chan (0 = rising/left, 1 = falling/right).
//
// state     | meaning
// ST_IDLE   | PDM clock held low, waiting for enable
// ST_WARMUP | PDM clock running, bits discarded, counting rising edges
// ST_RUN    | bits captured and decimation frames counted
module tqvp_jnms_pdm_seq #(
    parameter int DIV_W   = 8,
    parameter int WARM_W  = 16,
    parameter int DECIM_W = 8
) (
    input logic                clk,
    input logic                rst,
    tqvp_jnms_pdm_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_RUN    = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
    localparam logic [WARM_W-1:0]  WARM_ONE  = 1;
    localparam logic [DECIM_W-1:0] DECIM_ONE = 1;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   hp_q, hp_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [WARM_W-1:0]  warmup_q, warmup_d;
    logic [DECIM_W-1:0] decim_cnt_q, decim_cnt_d;
    logic [DECIM_W-1:0] ratio_q, ratio_d;
    logic               edge_sel_q, edge_sel_d;
    logic               pdm_clk_q, pdm_clk_d;
    logic               bit_valid_q, bit_valid_d;
    logic               bit_data_q, bit_data_d;
    logic               pcm_tick_q, pcm_tick_d;
    logic               irq_q, irq_d;
    logic               overrun_q, overrun_d;
`ifdef TQVP_JNMS_PDM_STEREO_EN
    logic               bit_chan_q, bit_chan_d;
`endif

    logic div_tc, rise_evt, fall_evt, sample_evt, count_evt;

    // Edge events describe the PDM clock change scheduled for this clk edge.
    assign div_tc   = (div_cnt_q == hp_q - DIV_ONE);
    assign rise_evt = (state_q != ST_IDLE) && div_tc && !pdm_clk_q;
    assign fall_evt = (state_q != ST_IDLE) && div_tc && pdm_clk_q;

`ifdef TQVP_JNMS_PDM_STEREO_EN
    assign sample_evt = rise_evt | fall_evt;
    assign count_evt  = fall_evt;
`else
    assign sample_evt = edge_sel_q ? fall_evt : rise_evt;
    assign count_evt  = sample_evt;
`endif

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        hp_d        = hp_q;
        warm_cnt_d  = warm_cnt_q;
        warmup_d    = warmup_q;
        decim_cnt_d = decim_cnt_q;
        ratio_d     = ratio_q;
        edge_sel_d  = edge_sel_q;
        pdm_clk_d   = pdm_clk_q;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data_q;
        pcm_tick_d  = 1'b0;
`ifdef TQVP_JNMS_PDM_STEREO_EN
        bit_chan_d  = bit_chan_q;
`endif

        // A tick acknowledged in the same cycle keeps irq set without overrun.
        irq_d     = pcm_tick_q | (irq_q & ~bus.sample_ack);
        overrun_d = (pcm_tick_q & irq_q & ~bus.sample_ack) | (overrun_q & ~bus.overrun_clr);

        if (state_q == ST_IDLE) begin
            pdm_clk_d = 1'b0;
            div_cnt_d = '0;
            if (bus.enable) begin
                hp_d        = (bus.clk_half_period == '0) ? DIV_ONE : bus.clk_half_period;
                warmup_d    = bus.warmup_periods;
                ratio_d     = bus.decim_ratio;
                edge_sel_d  = bus.edge_sel;
                warm_cnt_d  = '0;
                decim_cnt_d = '0;
                state_d     = ST_WARMUP;
            end
        end else if (!bus.enable) begin
            state_d     = ST_IDLE;
            pdm_clk_d   = 1'b0;
            div_cnt_d   = '0;
            warm_cnt_d  = '0;
            decim_cnt_d = '0;
        end else begin
            if (div_tc) begin
                div_cnt_d = '0;
                pdm_clk_d = ~pdm_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end

            if (state_q == ST_WARMUP) begin
                if (rise_evt) warm_cnt_d = warm_cnt_q + WARM_ONE;
                if (warmup_q == '0 || (rise_evt && warm_cnt_q == warmup_q - WARM_ONE))
                    state_d = ST_RUN;
            end else if (sample_evt) begin
                bit_valid_d = 1'b1;
                bit_data_d  = bus.pdm_data_in;
`ifdef TQVP_JNMS_PDM_STEREO_EN
                bit_chan_d  = fall_evt;
`endif
                // ratio 0 wraps to all-ones here, giving a 2^DECIM_W frame.
                if (count_evt) begin
                    if (decim_cnt_q == ratio_q - DECIM_ONE) begin
                        pcm_tick_d  = 1'b1;
                        decim_cnt_d = '0;
                    end else begin
                        decim_cnt_d = decim_cnt_q + DECIM_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            hp_q        <= '0;
            warm_cnt_q  <= '0;
            warmup_q    <= '0;
            decim_cnt_q <= '0;
            ratio_q     <= '0;
            edge_sel_q  <= 1'b0;
            pdm_clk_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            pcm_tick_q  <= 1'b0;
            irq_q       <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef TQVP_JNMS_PDM_STEREO_EN
            bit_chan_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            hp_q        <= hp_d;
            warm_cnt_q  <= warm_cnt_d;
            warmup_q    <= warmup_d;
            decim_cnt_q <= decim_cnt_d;
            ratio_q     <= ratio_d;
            edge_sel_q  <= edge_sel_d;
            pdm_clk_q   <= pdm_clk_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            pcm_tick_q  <= pcm_tick_d;
            irq_q       <= irq_d;
            overrun_q   <= overrun_d;
`ifdef TQVP_JNMS_PDM_STEREO_EN
            bit_chan_q  <= bit_chan_d;
`endif
        end
    end

    assign bus.pdm_clk_out = pdm_clk_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_data    = bit_data_q;
    assign bus.pcm_tick    = pcm_tick_q;
    assign bus.state       = state_q;
    assign bus.irq         = irq_q;
    assign bus.overrun     = overrun_q;
`ifdef TQVP_JNMS_PDM_STEREO_EN
    assign bus.bit_chan    = bit_chan_q;
`endif
endmodule

// File: tb/tb_tqvp_jnms_pdm_seq.sv
// Self-checking bench for tqvp_jnms_pdm_seq (mono build).
// A time-based model (cycle index since enable -> PDM clock level, edge
// counts, bit counts) predicts every output each cycle; directed sections
// pin literal values for divider, warm-up, edge select, decimation,
// interrupt, disable and reset behaviour.
module tb_tqvp_jnms_pdm_seq;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tqvp_jnms_pdm_seq_if #(.DIV_W(8), .WARM_W(16), .DECIM_W(8)) bus ();

    tqvp_jnms_pdm_seq #(.DIV_W(8), .WARM_W(16), .DECIM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         active;
        int         t;
        int         hp;
        int         w;
        int         ratio;
        int         nbits;
        bit         es;
        logic       clk_o;
        logic       bv;
        logic       bd;
        logic       tick;
        logic       irq;
        logic       ovr;
        logic [1:0] st;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.active = 0; r.t = 0; r.hp = 1; r.w = 0; r.ratio = 1; r.nbits = 0; r.es = 0;
        r.clk_o = 0; r.bv = 0; r.bd = 0; r.tick = 0; r.irq = 0; r.ovr = 0; r.st = 2'd0;
        return r;
    endfunction

    // Rising PDM edges happen at t = hp*(2k+1) after entering warm-up.
    function automatic int rises(int t, int hp);
        return (t >= hp) ? (t / hp + 1) / 2 : 0;
    endfunction

    function automatic bit run_at(model_t s, int t);
        if (s.w == 0) return t >= 1;
        return rises(t, s.hp) >= s.w;
    endfunction

    function automatic model_t model_step(model_t s, logic en, logic [7:0] hp_in,
                                          logic [15:0] w_in, logic [7:0] d_in,
                                          logic es_in, logic din, logic ack, logic oclr);
        model_t n = s;
        n.irq  = s.tick ? 1'b1 : (ack ? 1'b0 : s.irq);
        n.ovr  = (s.tick && s.irq && !ack) ? 1'b1 : (oclr ? 1'b0 : s.ovr);
        n.bv   = 0;
        n.tick = 0;
        if (!s.active) begin
            n.clk_o = 0;
            n.st    = 2'd0;
            if (en) begin
                n.active = 1;
                n.t      = 0;
                n.hp     = (hp_in == 0) ? 1 : int'(hp_in);
                n.w      = int'(w_in);
                n.ratio  = (d_in == 0) ? 256 : int'(d_in);
                n.es     = es_in;
                n.nbits  = 0;
                n.st     = 2'd1;
            end
        end else if (!en) begin
            n.active = 0;
            n.st     = 2'd0;
            n.clk_o  = 0;
        end else begin
            n.t     = s.t + 1;
            n.clk_o = ((n.t / s.hp) % 2) == 1;
            if (run_at(s, s.t) && n.clk_o != s.clk_o && n.clk_o == !s.es) begin
                n.bv    = 1;
                n.bd    = din;
                n.nbits = s.nbits + 1;
                n.tick  = (n.nbits % s.ratio) == 0;
            end
            n.st = run_at(s, n.t) ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, bus.enable, bus.clk_half_period, bus.warmup_periods,
                                 bus.decim_ratio, bus.edge_sel, bus.pdm_data_in,
                                 bus.sample_ack, bus.overrun_clr);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no event within cycle budget at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("pdm_clk_out", int'(bus.pdm_clk_out), int'(m.clk_o));
            chk("bit_valid",   int'(bus.bit_valid),   int'(m.bv));
            chk("bit_data",    int'(bus.bit_data),    int'(m.bd));
            chk("pcm_tick",    int'(bus.pcm_tick),    int'(m.tick));
            chk("state",       int'(bus.state),       int'(m.st));
            chk("irq",         int'(bus.irq),         int'(m.irq));
            chk("overrun",     int'(bus.overrun),     int'(m.ovr));
        end
    end

    task automatic set_cfg(input int hp, input int w, input int d, input int es);
        bus.clk_half_period = 8'(hp);
        bus.warmup_periods  = 16'(w);
        bus.decim_ratio     = 8'(d);
        bus.edge_sel        = 1'(es);
    endtask

    // Returns at the negedge of the tick cycle; n counts bit_valid cycles seen.
    task automatic wait_tick(input string name, input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.pdm_data_in = 1'($urandom_range(0, 1));
            if (bus.bit_valid) n++;
            if (bus.pcm_tick) begin
                chk({name, "_tick_with_valid"}, int'(bus.bit_valid), 1);
                return;
            end
        end
        timeout(name);
        n = -1;
    endtask

    task automatic measure_clk(input int hp, input int hp_eff);
        int prev, r1, r2, f1;
        prev = 0; r1 = -1; r2 = -1; f1 = -1;
        set_cfg(hp, 0, 4, 0);
        @(negedge clk); bus.enable = 1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            bus.pdm_data_in = 1'($urandom_range(0, 1));
            if (bus.pdm_clk_out && prev == 0) begin
                if (r1 < 0) r1 = t;
                else if (r2 < 0) r2 = t;
            end
            if (!bus.pdm_clk_out && prev == 1 && r1 >= 0 && f1 < 0) f1 = t;
            prev = int'(bus.pdm_clk_out);
        end
        bus.enable = 0;
        @(negedge clk);
        chk("div_first_rise", r1, hp_eff);
        chk("div_period", r2 - r1, 2 * hp_eff);
        chk("div_high_time", f1 - r1, hp_eff);
    endtask

    initial begin
        int n, t_run, t_bv, bad, offph, nb;
        rst = 1'b1;
        bus.enable = 0; bus.pdm_data_in = 0; bus.sample_ack = 0; bus.overrun_clr = 0;
        set_cfg(5, 0, 4, 0);
        repeat (3) @(negedge clk);
        chk("rst_pdm_clk", int'(bus.pdm_clk_out), 0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_irq", int'(bus.irq), 0);
        rst = 1'b0;
        @(negedge clk);

        // Divider
        measure_clk(5, 5);
        measure_clk(0, 1);

        // Warm-up: hp=2, warmup=3
        set_cfg(2, 3, 4, 0);
        t_run = -1; t_bv = -1;
        @(negedge clk); bus.enable = 1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (bus.state == 2'd2 && t_run < 0) t_run = t;
            if (bus.bit_valid && t_bv < 0) t_bv = t;
        end
        bus.enable = 0;
        @(negedge clk);
        chk("warm_run_cycle", t_run, 10);
        chk("warm_first_valid_cycle", t_bv, 14);

        // Edge select: falling-edge capture of alternating data; edge_sel change ignored
        set_cfg(2, 0, 3, 1);
        bad = 0; offph = 0; nb = 0;
        @(negedge clk); bus.enable = 1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.bit_valid) begin
                if (int'(bus.bit_data) != ((nb % 2 == 0) ? 1 : 0)) bad++;
                if (t % 4 != 0) offph++;
                nb++;
            end
            bus.pdm_data_in = ((t / 4) % 2 == 0);
            if (t == 20) bus.edge_sel = 0;
        end
        bus.enable = 0;
        @(negedge clk);
        chk("es_pattern_errors", bad, 0);
        chk("es_off_falling_edge", offph, 0);
        chk("es_bit_count", nb, 14);

        // Decimation
        set_cfg(0, 0, 4, 0);
        @(negedge clk); bus.enable = 1;
        wait_tick("decim4_a", 200, n); chk("decim4_first", n, 4);
        wait_tick("decim4_b", 200, n); chk("decim4_second", n, 4);
        bus.enable = 0;
        @(negedge clk);
        set_cfg(0, 0, 0, 0);
        bus.enable = 1;
        wait_tick("decim256", 2000, n); chk("decim256_bits", n, 256);
        bus.enable = 0;

        // Interrupt / overrun
        @(negedge clk);
        bus.sample_ack = 1; bus.overrun_clr = 1;
        @(negedge clk);
        bus.sample_ack = 0; bus.overrun_clr = 0;
        @(negedge clk);
        chk("irq_cleared", int'(bus.irq), 0);
        chk("ovr_cleared", int'(bus.overrun), 0);
        set_cfg(0, 0, 2, 0);
        bus.enable = 1;
        wait_tick("irq_t1", 100, n);
        @(negedge clk);
        chk("irq_after_tick", int'(bus.irq), 1);
        wait_tick("irq_t2", 100, n);
        bus.sample_ack = 1;
        @(negedge clk);
        bus.sample_ack = 0;
        chk("ack_with_tick_irq", int'(bus.irq), 1);
        chk("ack_with_tick_ovr", int'(bus.overrun), 0);
        wait_tick("irq_t3", 100, n);
        @(negedge clk);
        chk("overrun_set", int'(bus.overrun), 1);
        bus.enable = 0;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_retained_idle", int'(bus.overrun), 1);
        bus.overrun_clr = 1;
        @(negedge clk);
        bus.overrun_clr = 0;
        chk("overrun_clr", int'(bus.overrun), 0);
        bus.sample_ack = 1;
        @(negedge clk);
        bus.sample_ack = 0;
        chk("irq_ack", int'(bus.irq), 0);

        // Disable mid-frame after 2 of 4 bits, then re-enable with warmup=0
        set_cfg(0, 0, 4, 0);
        bus.enable = 1;
        nb = 0;
        for (int i = 0; i < 100 && nb < 2; i++) begin
            @(negedge clk);
            bus.pdm_data_in = 1'($urandom_range(0, 1));
            if (bus.bit_valid) nb++;
        end
        if (nb < 2) timeout("disable_two_bits");
        bus.enable = 0;
        @(negedge clk);
        chk("dis_pdm_clk", int'(bus.pdm_clk_out), 0);
        chk("dis_state", int'(bus.state), 0);
        chk("dis_no_tick", int'(bus.pcm_tick), 0);
        chk("dis_no_valid", int'(bus.bit_valid), 0);
        bus.enable = 1;
        wait_tick("reenable", 200, n);
        chk("reenable_bits", n, 4);

        // Asynchronous reset mid-RUN
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_pdm_clk", int'(bus.pdm_clk_out), 0);
        chk("arst_valid", int'(bus.bit_valid), 0);
        chk("arst_data", int'(bus.bit_data), 0);
        chk("arst_tick", int'(bus.pcm_tick), 0);
        chk("arst_state", int'(bus.state), 0);
        chk("arst_irq", int'(bus.irq), 0);
        chk("arst_ovr", int'(bus.overrun), 0);
        bus.enable = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized segments checked by the model
        for (int s = 0; s < 8; s++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1));
            @(negedge clk);
            bus.enable = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                bus.pdm_data_in = 1'($urandom_range(0, 1));
                bus.sample_ack  = ($urandom_range(0, 7) == 0);
                bus.overrun_clr = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 49) == 0)
                    set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1));
                bus.enable = ($urandom_range(0, 149) != 0);
            end
            bus.enable = 0; bus.sample_ack = 0; bus.overrun_clr = 0;
            repeat (2) @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tqvp_jnms_pdm_seq.md
Name: tqvp_jnms_pdm_seq

Overview:
Capture sequencer for the PDM microphone peripheral. It generates the microphone clock from the 64 MHz project clock and runs a power-up warm-up period during which samples are discarded. It then samples the PDM data pin on a programmable edge, forwards each bit to the downstream decimator, and issues a PCM tick every decim_ratio bits. It also owns the sample-ready interrupt and overrun flag seen by the TinyQV register block.

Parameters:
DIV_W, 8, width of clk_half_period
WARM_W, 16, width of warmup_periods
DECIM_W, 8, width of decim_ratio and decimation counter

Ports:
clk  in  1  project clock, 64 MHz
rst  in  1  asynchronous active-high reset
enable  in  1  capture enable, from the control register bit 0
clk_half_period  in  DIV_W  PDM clock half-period in clk cycles; 0 is treated as 1
warmup_periods  in  WARM_W  PDM clock periods discarded after enable
decim_ratio  in  DECIM_W  bits per PCM tick; 0 is treated as 2^DECIM_W
edge_sel  in  1  0: sample at PDM clock rising edge, 1: sample at falling edge
pdm_data_in  in  1  microphone data, already synchronized
sample_ack  in  1  one-cycle pulse; clears irq
overrun_clr  in  1  one-cycle pulse; clears overrun
pdm_clk_out  out  1  microphone clock, registered
bit_valid  out  1  one-cycle strobe, bit_data valid
bit_data  out  1  captured PDM bit
pcm_tick  out  1  one-cycle strobe; the decimator emits a PCM word
state  out  2  00 IDLE, 01 WARMUP, 10 RUN
irq  out  1  sample-ready pending
overrun  out  1  sticky; a tick arrived while irq was still pending

Behaviour:
- Reset (asynchronous, any time): state IDLE; all counters 0; pdm_clk_out, bit_valid, bit_data, pcm_tick, irq and overrun all 0.
- Configuration latching: clk_half_period, warmup_periods, decim_ratio and edge_sel are latched on the IDLE->WARMUP transition. Changes made while in WARMUP or RUN are ignored until the next enable cycle.
- IDLE: pdm_clk_out is held at 0. When enable=1, latch the configuration, clear the divider, warm-up and decimation counters, and go to WARMUP.
- Divider:
  - Counter runs 0..hp-1, where hp is the latched half-period.
  - At terminal count, pdm_clk_out toggles on the next clk edge and the counter returns to 0.
  - The first toggle (0->1) occurs hp cycles after entering WARMUP.
  - PDM clock period is 2*hp clk cycles; hp=5 gives 6.4 MHz.
- Sampling:
  - A sample event is the clk edge on which pdm_clk_out changes to the edge selected by edge_sel.
  - pdm_data_in is captured into bit_data on that clk edge.
- WARMUP:
  - Each PDM rising edge increments the warm-up counter.
  - When the count equals warmup_periods, go to RUN on the same edge.
  - warmup_periods=0 goes to RUN one cycle after entering WARMUP.
  - No bit_valid is produced in WARMUP.
- RUN:
  - Each sample event raises bit_valid for the one following cycle.
  - Each bit_valid increments the decimation counter.
  - When the bit_valid cycle carries the decim_ratio-th bit, pcm_tick is high in that same cycle and the counter returns to 0.
- Interrupt:
  - pcm_tick sets irq; sample_ack clears it.
  - pcm_tick and sample_ack in the same cycle: irq stays 1 and overrun is not set.
  - pcm_tick while irq=1 and no ack in that cycle sets overrun.
  - overrun_clr clears overrun; if it coincides with a new overrun event, the set wins.
- Disable (enable=0 in WARMUP or RUN):
  - Next cycle: state IDLE and pdm_clk_out=0.
  - Counters are cleared; a partial decimation frame is discarded with no tick.
  - A bit_valid already scheduled for that cycle is suppressed.
  - irq and overrun are retained.
- Re-enable always restarts the full warm-up.

Optional Feature:
Macro TQVP_JNMS_PDM_STEREO_EN.
- With the macro:
  - Both PDM clock edges are sample events; edge_sel is ignored.
  - An extra output bit_chan (1 bit) marks each bit: 0 for a rising-edge (left) bit, 1 for a falling-edge (right) bit.
  - The decimation counter increments only on chan-1 bits, so pcm_tick coincides with the right-channel bit that completes the frame.
  - Warm-up is still counted in rising edges.
- Without the macro: mono capture as described above; no bit_chan port.

Test Plan:
- Divider: hp=5, warmup=0, enable → pdm_clk_out period is 10 cycles with 50% duty. hp=0 → period 2 cycles.
- Warm-up: hp=2, warmup=3 → state=RUN after the 3rd rising edge; no bit_valid before it; first bit_valid one cycle after the 4th rising edge (edge_sel=0).
- Edge select:
  - Drive pdm_data_in with the alternating pattern 1,0,1,0,... (one value per PDM clock period), edge_sel=1 → bit_data follows the pattern, each bit captured at a falling edge.
  - Change edge_sel mid-RUN → no effect until re-enable.
- Decimation: decim=4 → pcm_tick on every 4th bit_valid, in the same cycle. decim=0 → tick every 256 bits.
- Interrupt: two ticks without ack → overrun=1. Ack coinciding with a tick → irq=1, overrun=0. overrun_clr → 0.
- Disable mid-frame after 2 of 4 bits, then re-enable with warmup=0:
  - After disable: pdm_clk_out=0 the next cycle, state=IDLE, no tick.
  - After re-enable: the first tick comes after 4 new bits.
  - Assert rst mid-RUN → all outputs 0 immediately.
